// File: rtl/up_dn_cntr_lim_if.sv
// Bundles the up_dn_cntr_lim control, limit and status signals; the wrap_i
// select exists only when UP_DN_CNTR_LIM_WRAP_EN is defined.
interface up_dn_cntr_lim_if #(
    parameter int WIDTH = 4
);
    logic             en_i;
    logic             sense_i;
    logic [WIDTH-1:0] step_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] lo_lim_i;
    logic [WIDTH-1:0] hi_lim_i;
`ifdef UP_DN_CNTR_LIM_WRAP_EN
    logic             wrap_i;
`endif
    logic [WIDTH-1:0] cntr_o;
    logic             at_max_o;
    logic             at_min_o;
    logic             ovf_o;
    logic             unf_o;
    logic             cfg_err_o;

    modport master (
        output en_i, sense_i, step_i, load_i, load_val_i, lo_lim_i, hi_lim_i,
`ifdef UP_DN_CNTR_LIM_WRAP_EN
        output wrap_i,
`endif
        input  cntr_o, at_max_o, at_min_o, ovf_o, unf_o, cfg_err_o
    );

    modport slave (
        input  en_i, sense_i, step_i, load_i, load_val_i, lo_lim_i, hi_lim_i,
`ifdef UP_DN_CNTR_LIM_WRAP_EN
        input  wrap_i,
`endif
        output cntr_o, at_max_o, at_min_o, ovf_o, unf_o, cfg_err_o
    );
endinterface

// File: rtl/up_dn_cntr_lim.sv
// Up/down counter with programmable inclusive limits, variable step, load and
// saturate-or-wrap handling; per-cycle wrap select needs UP_DN_CNTR_LIM_WRAP_EN.
module up_dn_cntr_lim #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic              clk_i,
    input logic              rst_i,
    up_dn_cntr_lim_if.slave  bus
);
    localparam int XW = WIDTH + 1;

    logic [WIDTH-1:0] cntr_q, cntr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // One extra bit keeps sums, signed differences and a full 2^WIDTH range exact.
    logic [XW-1:0] cnt_x, lo_x, hi_x, step_x, range_x, sum_x, diff_x;
    logic          cfg_err;
    logic          wrap_mode;

    assign cnt_x   = {1'b0, cntr_q};
    assign lo_x    = {1'b0, bus.lo_lim_i};
    assign hi_x    = {1'b0, bus.hi_lim_i};
    assign step_x  = {1'b0, bus.step_i};
    assign range_x = hi_x - lo_x + XW'(1);
    assign sum_x   = cnt_x + step_x;
    assign diff_x  = cnt_x - step_x;
    assign cfg_err = bus.lo_lim_i > bus.hi_lim_i;

`ifdef UP_DN_CNTR_LIM_WRAP_EN
    assign wrap_mode = bus.wrap_i;
`else
    assign wrap_mode = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        cntr_d = cntr_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (cfg_err) begin
            cntr_d = cntr_q;
        end else if (bus.load_i) begin
            if (bus.load_val_i > bus.hi_lim_i)      cntr_d = bus.hi_lim_i;
            else if (bus.load_val_i < bus.lo_lim_i) cntr_d = bus.lo_lim_i;
            else                                    cntr_d = bus.load_val_i;
        end else if (bus.en_i) begin
            // An out-of-range start is pulled back to the violated limit silently.
            if (cnt_x > hi_x) begin
                cntr_d = bus.hi_lim_i;
            end else if (cnt_x < lo_x) begin
                cntr_d = bus.lo_lim_i;
            end else if (bus.sense_i) begin
                if (sum_x <= hi_x) begin
                    cntr_d = sum_x[WIDTH-1:0];
                end else begin
                    ovf_d = 1'b1;
                    if (wrap_mode && (step_x <= range_x)) cntr_d = WIDTH'(sum_x - range_x);
                    else                                  cntr_d = bus.hi_lim_i;
                end
            end else begin
                if ($signed(diff_x) >= $signed(lo_x)) begin
                    cntr_d = diff_x[WIDTH-1:0];
                end else begin
                    unf_d = 1'b1;
                    if (wrap_mode && (step_x <= range_x)) cntr_d = WIDTH'(diff_x + range_x);
                    else                                  cntr_d = bus.lo_lim_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst_i) begin
            cntr_q <= RST_VAL;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cntr_q <= cntr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.cntr_o    = cntr_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.unf_o     = unf_q;
    assign bus.at_max_o  = cntr_q == bus.hi_lim_i;
    assign bus.at_min_o  = cntr_q == bus.lo_lim_i;
    assign bus.cfg_err_o = cfg_err;
endmodule

// File: doc/up_dn_cntr_lim.md
# up_dn_cntr_lim

Parametrised up/down counter with runtime-programmable lower/upper limits, variable step, synchronous load, and saturate-or-wrap boundary handling. It is the general-purpose successor to the fixed 4-bit saturating up/down counter. It serves as a credit, occupancy and level counter across the design. It reports limit status and single-cycle overflow/underflow events to the surrounding control logic.

## Interface
- WIDTH, 4: counter width in bits (≥2).
- RST_VAL, 0: value loaded on reset (WIDTH bits, loaded verbatim).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; one step per cycle when high.
- sense  input  1  direction: 1 up, 0 down.
- step  input  WIDTH  step magnitude; 0 means hold.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  load value.
- lo_lim  input  WIDTH  lower limit, inclusive.
- hi_lim  input  WIDTH  upper limit, inclusive.
- wrap  input  1  1: wrap at limits, 0: saturate (present only with UP_DN_CNTR_LIM_WRAP_EN).
- cntr  output  WIDTH  registered count.
- at_max  output  1  combinational: cntr == hi_lim.
- at_min  output  1  combinational: cntr == lo_lim.
- ovf  output  1  registered one-cycle pulse: an up step crossed hi_lim.
- unf  output  1  registered one-cycle pulse: a down step crossed lo_lim.
- cfg_err  output  1  combinational: lo_lim > hi_lim.

## Operation
- Priority per edge: rst > cfg_err > load > en; otherwise hold.
- rst: cntr=RST_VAL, ovf=0, unf=0.
- cfg_err high: cntr holds; ovf and unf are 0; load and en are ignored.
- load: cntr = load_val clamped to [lo_lim, hi_lim]. No ovf or unf pulse.
- Arithmetic is done in WIDTH+1 bits. range = hi_lim − lo_lim + 1, which can be up to 2^WIDTH.
- Out-of-range start: with en=1, if cntr > hi_lim the next value is hi_lim; if cntr < lo_lim it is lo_lim. This applies regardless of sense or step, and does not pulse ovf or unf.
- Up (en=1, sense=1), sum = cntr + step:
  - sum ≤ hi_lim → cntr = sum.
  - sum > hi_lim and saturating → cntr = hi_lim, ovf=1.
  - sum > hi_lim and wrapping → cntr = sum − range, ovf=1.
- Down (en=1, sense=0), diff = cntr − step, signed in WIDTH+1 bits:
  - diff ≥ lo_lim → cntr = diff.
  - diff < lo_lim and saturating → cntr = lo_lim, unf=1.
  - diff < lo_lim and wrapping → cntr = diff + range, unf=1.
- An en step that starts at a limit and pushes past it still pulses ovf/unf, including in saturate mode when the value does not change.
- Wrap mode requires step ≤ range. If step > range, the result is saturated to the limit instead, and ovf/unf still pulse.
- ovf and unf are mutually exclusive. They are 0 on every cycle without an en boundary crossing.

## Timing
- Load-to-cntr and step-to-cntr latency: 1 clock.
- ovf/unf assert in the same cycle the updated cntr appears, for exactly one cycle per crossing. Back-to-back crossings give back-to-back pulses.
- at_max, at_min and cfg_err follow cntr and the limit inputs combinationally; there is no added latency.
- Limit changes take effect on the next edge. cntr is not re-clamped unless en or load is active.
- Reset mid-count: the next edge forces RST_VAL and clears ovf/unf, regardless of en, load or cfg_err.

## Configuration
- UP_DN_CNTR_LIM_WRAP_EN defined: the wrap input port exists and selects wrap or saturate per cycle.
- Undefined: the wrap port is absent and the block always saturates. All other behaviour is identical.

## Test plan
- WIDTH=4, lo=0, hi=15, step=1, sense=1, en for 18 cycles from reset → cntr 1..15 then holds 15; at_max from cycle 15; ovf pulses on cycles 16, 17, 18.
- lo=3, hi=12, wrap=1, load 11, step=3 up → cntr 14−10=4, ovf=1 for one cycle; next step down by 3 → 1+10=11, unf=1.
- lo=3, hi=12, saturate, load_val=14 → cntr=12 with no ovf; load_val=0 → cntr=3; same-cycle load=1 and en=1 → load wins.
- Set lo=9, hi=5 with en=1 and load=1 → cfg_err=1, cntr holds, no pulses; restore lo=0 → counting resumes next edge.
- cntr=10, change hi to 6, en=1 down step 1 → cntr=6 with no unf; then steps 5, 4, ….
- Assert rst during wrap counting with ovf high → next cycle cntr=RST_VAL, ovf=0, unf=0.
